// File: rtl/reg_bank_reader_if.sv
// Request/response bundle between the register-bank reader and its consumer.
// The master side issues read requests and accepts response words.
interface reg_bank_reader_if #(
    parameter int NREGS = 8,
    parameter int W     = 10
);
    localparam int IW = $clog2(NREGS);

    logic          ReqValid;
    logic [IW-1:0] ReqIdx;
    logic [IW-1:0] ReqLen;
    logic          ReqReady;
    logic          RspValid;
    logic [W-1:0]  RspData;
    logic [IW-1:0] RspIdx;
    logic          RspLast;
    logic          RspReady;

    modport master (
        output ReqValid, ReqIdx, ReqLen, RspReady,
        input  ReqReady, RspValid, RspData, RspIdx, RspLast
    );

    modport slave (
        input  ReqValid, ReqIdx, ReqLen, RspReady,
        output ReqReady, RspValid, RspData, RspIdx, RspLast
    );
endinterface

// File: rtl/reg_bank_reader.sv
// Burst reader for the flattened register bank: walks indices with wrap-around
// and returns words through a small show-ahead FIFO. All state moves on negedge Clkb.
module reg_bank_reader #(
    parameter int NREGS = 8,
    parameter int W     = 10,
    parameter int DEPTH = 2
) (
    input  logic                 Clkb,
    input  logic                 Reset,
    input  logic [NREGS*W-1:0]   RegBank,
    reg_bank_reader_if.slave     bus,
    output logic                 Busy
);
    localparam int IW = $clog2(NREGS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = W + IW + 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] cur_reg, cur_next;
    logic [IW-1:0] rem_reg, rem_next;

    logic [W-1:0]  bank_word [NREGS];

    logic [EW-1:0] fifo_mem [DEPTH];
    logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0] count_reg;

    logic          fifo_full;
    logic          fifo_valid;
    logic          push;
    logic          pop;
    logic          req_ready;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head_entry;

    // Unpack the flattened bank into an indexable array of words.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_bank
            assign bank_word[gi] = RegBank[gi*W +: W];
        end
    endgenerate

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_full  = (count_reg == CW'(DEPTH));
    assign fifo_valid = (count_reg != '0);
    assign pop        = fifo_valid & bus.RspReady;
    assign push_entry = {bank_word[cur_reg], cur_reg, (rem_reg == '0)};
    assign head_entry = fifo_mem[rd_ptr_reg];

    always_ff @(negedge Clkb) begin
        if (Reset) begin
            state_reg <= IDLE;
            cur_reg   <= '0;
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cur_reg   <= cur_next;
            rem_reg   <= rem_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        rem_next   = rem_reg;
        req_ready  = 1'b0;
        push       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.ReqValid) begin
                    cur_next   = bus.ReqIdx;
                    rem_next   = bus.ReqLen;
                    state_next = BURST;
                end
            end
            BURST: begin
                // A full FIFO still takes a word when the head leaves on the same edge.
                if (!fifo_full || pop) begin
                    push     = 1'b1;
                    cur_next = cur_reg + IW'(1);
                    rem_next = rem_reg - IW'(1);
                    if (rem_reg == '0) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(negedge Clkb) begin
        if (Reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            unique case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(negedge Clkb) begin
        if (push && !Reset) begin
            fifo_mem[wr_ptr_reg] <= push_entry;
        end
    end

    assign bus.ReqReady = req_ready;
    assign bus.RspValid = fifo_valid;
    assign bus.RspData  = fifo_valid ? head_entry[EW-1 -: W]  : '0;
    assign bus.RspIdx   = fifo_valid ? head_entry[IW:1]       : '0;
    assign bus.RspLast  = fifo_valid ? head_entry[0]          : 1'b0;
    assign Busy         = (state_reg == BURST) | fifo_valid;

endmodule
